// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light encodings, controller state type and siren timing defaults
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } light_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HOLDOFF = 1'b1
  } ctrl_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 3;
  localparam int DEFAULT_HOLDOFF_CYCLES  = 20;

  // Drop counter adds up to two per edge and sticks at 15 rather than wrapping.
  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [1:0] inc);
    logic [4:0] sum;
    sum = {1'b0, a} + {3'b000, inc};
    return (sum > 5'd15) ? 4'd15 : sum[3:0];
  endfunction

endpackage

// File: rtl/emergency_request_conditioner_if.sv
// rtl/emergency_request_conditioner_if.sv - siren inputs and emergency request outputs
interface emergency_request_conditioner_if;
  logic       Siren_Left_raw;
  logic       Siren_Right_raw;
  logic       Emergency_Left;
  logic       Emergency_Right;
  logic       Siren_Active_Left;
  logic       Siren_Active_Right;
  logic       Pending_Left;
  logic       Pending_Right;
  logic [3:0] Dropped_Count;

  modport master (
    output Siren_Left_raw, Siren_Right_raw,
    input  Emergency_Left, Emergency_Right, Siren_Active_Left, Siren_Active_Right,
    input  Pending_Left, Pending_Right, Dropped_Count
  );

  modport slave (
    input  Siren_Left_raw, Siren_Right_raw,
    output Emergency_Left, Emergency_Right, Siren_Active_Left, Siren_Active_Right,
    output Pending_Left, Pending_Right, Dropped_Count
  );
endinterface

// File: rtl/emergency_request_conditioner_debouncer.sv
// rtl/emergency_request_conditioner_debouncer.sv - siren synchronizer, debounce counter and rising-edge detect
module siren_debouncer
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_active,
  output logic o_rise
);
  localparam logic [3:0] LP_TARGET = 4'(DEBOUNCE_CYCLES);

  logic [1:0] r_sync;
  logic [3:0] r_cnt;
  logic       r_active;
  logic       r_active_d;
  logic [3:0] w_cnt_nxt;

  // Counter parks at the target so a long siren cannot overflow it.
  assign w_cnt_nxt = (r_cnt == LP_TARGET) ? r_cnt : r_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= 2'b00;
      r_cnt      <= 4'd0;
      r_active   <= 1'b0;
      r_active_d <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], i_raw};
      r_active_d <= r_active;
      if (r_sync[1]) begin
        r_cnt    <= w_cnt_nxt;
        r_active <= (w_cnt_nxt == LP_TARGET);
      end else begin
        r_cnt    <= 4'd0;
        r_active <= 1'b0;
      end
    end
  end

  assign o_active = r_active;
  assign o_rise   = r_active & ~r_active_d;
endmodule

// File: rtl/emergency_request_conditioner.sv
// rtl/emergency_request_conditioner.sv - debounces two sirens and issues rate-limited emergency pulses
module emergency_request_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLDOFF_CYCLES  = DEFAULT_HOLDOFF_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  emergency_request_conditioner_if.slave bus
);
  localparam logic [7:0] LP_HOLD_RELOAD = 8'(HOLDOFF_CYCLES - 1);

  ctrl_state_t r_state, w_state_nxt;
  logic [7:0]  r_hold_cnt, w_hold_cnt_nxt;
  logic        r_pend_l, r_pend_r, w_pend_l_nxt, w_pend_r_nxt;
  logic        r_emerg_l, r_emerg_r, w_emerg_l_nxt, w_emerg_r_nxt;
  logic [3:0]  r_drop_cnt, w_drop_cnt_nxt;
  logic        w_active_l, w_active_r, w_rise_l, w_rise_r;
  logic        w_clr_l, w_clr_r, w_drop_l, w_drop_r;

  siren_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raw    (bus.Siren_Left_raw),
    .o_active (w_active_l),
    .o_rise   (w_rise_l)
  );

  siren_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raw    (bus.Siren_Right_raw),
    .o_active (w_active_r),
    .o_rise   (w_rise_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= 8'd0;
      r_pend_l   <= 1'b0;
      r_pend_r   <= 1'b0;
      r_emerg_l  <= 1'b0;
      r_emerg_r  <= 1'b0;
      r_drop_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_pend_l   <= w_pend_l_nxt;
      r_pend_r   <= w_pend_r_nxt;
      r_emerg_l  <= w_emerg_l_nxt;
      r_emerg_r  <= w_emerg_r_nxt;
      r_drop_cnt <= w_drop_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_emerg_l_nxt  = 1'b0;
    w_emerg_r_nxt  = 1'b0;
    w_clr_l        = 1'b0;
    w_clr_r        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_l | r_pend_r) begin
          w_emerg_l_nxt  = r_pend_l;
          w_emerg_r_nxt  = r_pend_r;
          w_clr_l        = r_pend_l;
          w_clr_r        = r_pend_r;
          w_hold_cnt_nxt = LP_HOLD_RELOAD;
          w_state_nxt    = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (r_hold_cnt == 8'd0) w_state_nxt = ST_IDLE;
        else                    w_hold_cnt_nxt = r_hold_cnt - 8'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // A new siren edge landing on the clearing edge re-arms the request instead of dropping it.
    w_drop_l       = w_rise_l & r_pend_l & ~w_clr_l;
    w_drop_r       = w_rise_r & r_pend_r & ~w_clr_r;
    w_pend_l_nxt   = w_rise_l | (r_pend_l & ~w_clr_l);
    w_pend_r_nxt   = w_rise_r | (r_pend_r & ~w_clr_r);
    w_drop_cnt_nxt = sat_add4(r_drop_cnt, {1'b0, w_drop_l} + {1'b0, w_drop_r});
  end

  assign bus.Emergency_Left     = r_emerg_l;
  assign bus.Emergency_Right    = r_emerg_r;
  assign bus.Siren_Active_Left  = w_active_l;
  assign bus.Siren_Active_Right = w_active_r;
  assign bus.Pending_Left       = r_pend_l;
  assign bus.Pending_Right      = r_pend_r;
  assign bus.Dropped_Count      = r_drop_cnt;
endmodule

// File: tb/tb_emergency_request_conditioner.sv
// tb/tb_emergency_request_conditioner.sv - bench for emergency_request_conditioner
module tb_emergency_request_conditioner;
  localparam int D = 3;
  localparam int H = 20;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  emergency_request_conditioner_if bus();

  emergency_request_conditioner #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: raw history windows decide debounce; issue times decide holdoff.
  logic [31:0] hl, hr;
  bit          m_pl, m_pr, m_el, m_er, m_al, m_ar;
  int          m_drops, m_cyc, m_next_ok;

  function automatic bit win(input logic [31:0] h, input int off);
    for (int j = off; j < off + D; j++) if (!h[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hl = '0; hr = '0;
    m_pl = 0; m_pr = 0; m_el = 0; m_er = 0; m_al = 0; m_ar = 0;
    m_drops = 0; m_next_ok = 0;
  endtask

  task automatic model_edge(input logic l, input logic r);
    bit rise_l, rise_r, issue, drop_l, drop_r;
    hl = {hl[30:0], l};
    hr = {hr[30:0], r};
    rise_l = win(hl, 3) && !win(hl, 4);
    rise_r = win(hr, 3) && !win(hr, 4);
    issue  = (m_pl || m_pr) && (m_cyc >= m_next_ok);
    m_el   = issue && m_pl;
    m_er   = issue && m_pr;
    drop_l = rise_l && m_pl && !m_el;
    drop_r = rise_r && m_pr && !m_er;
    m_pl   = rise_l || (m_pl && !m_el);
    m_pr   = rise_r || (m_pr && !m_er);
    m_drops = m_drops + int'(drop_l) + int'(drop_r);
    if (m_drops > 15) m_drops = 15;
    if (issue) m_next_ok = m_cyc + H + 1;
    m_al = win(hl, 2);
    m_ar = win(hr, 2);
    m_cyc++;
  endtask

  function automatic logic [10:0] dut_vec();
    return {bus.Emergency_Left, bus.Emergency_Right, bus.Siren_Active_Left, bus.Siren_Active_Right,
            bus.Pending_Left, bus.Pending_Right, bus.Dropped_Count};
  endfunction

  function automatic logic [10:0] model_vec();
    return {m_el, m_er, m_al, m_ar, m_pl, m_pr, 4'(m_drops)};
  endfunction

  task automatic step(input logic l, input logic r);
    bus.Siren_Left_raw  = l;
    bus.Siren_Right_raw = r;
    @(posedge clk);
    model_edge(l, r);
    #1;
  endtask

  task automatic apply_reset();
    bus.Siren_Left_raw  = 1'b0;
    bus.Siren_Right_raw = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Siren_Left_raw  = 1'b1;
    bus.Siren_Right_raw = 1'b1;
    model_reset();
    m_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dut_vec() !== 11'd0) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=%b", dut_vec(), 11'd0);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    total++;
    if (dut_vec() !== 11'd0) begin
      bad++;
      $display("FAIL reset_release got=%b exp=%b", dut_vec(), 11'd0);
    end
  endtask

  task automatic test_single_left();
    int nl, nr, at;
    apply_reset();
    nl = 0; nr = 0; at = -1;
    for (int i = 0; i < 40; i++) begin
      step(i < 10, 1'b0);
      if (bus.Emergency_Left) begin nl++; at = i; end
      if (bus.Emergency_Right) nr++;
    end
    total += 3;
    if (nl !== 1) begin bad++; $display("FAIL single_left_count got=%0d exp=1", nl); end
    if (at !== D + 3) begin bad++; $display("FAIL single_left_latency got=%0d exp=%0d", at, D + 3); end
    if (nr !== 0) begin bad++; $display("FAIL single_left_right got=%0d exp=0", nr); end
  endtask

  task automatic test_glitch();
    int act, np;
    apply_reset();
    act = 0; np = 0;
    for (int i = 0; i < 25; i++) begin
      step(1'b0, i < 2);
      if (bus.Siren_Active_Right) act++;
      if (bus.Emergency_Right || bus.Emergency_Left) np++;
    end
    total += 3;
    if (act !== 0) begin bad++; $display("FAIL glitch_active got=%0d exp=0", act); end
    if (np !== 0) begin bad++; $display("FAIL glitch_pulse got=%0d exp=0", np); end
    if (bus.Dropped_Count !== 4'd0) begin
      bad++; $display("FAIL glitch_drops got=%0d exp=0", bus.Dropped_Count);
    end
  endtask

  task automatic test_both();
    int nboth, nl, nr;
    apply_reset();
    nboth = 0; nl = 0; nr = 0;
    for (int i = 0; i < 40; i++) begin
      step(i < 10, i < 10);
      if (bus.Emergency_Left && bus.Emergency_Right && i == D + 3) nboth++;
      if (bus.Emergency_Left) nl++;
      if (bus.Emergency_Right) nr++;
    end
    total += 3;
    if (nboth !== 1) begin bad++; $display("FAIL both_together got=%0d exp=1", nboth); end
    if (nl !== 1) begin bad++; $display("FAIL both_left_count got=%0d exp=1", nl); end
    if (nr !== 1) begin bad++; $display("FAIL both_right_count got=%0d exp=1", nr); end
  endtask

  task automatic test_holdoff_queue();
    int tl, tr;
    logic pend_seen;
    apply_reset();
    tl = -1; tr = -1; pend_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(i < 10, (i >= 6) && (i < 16));
      if (bus.Emergency_Left && tl < 0) tl = i;
      if (bus.Emergency_Right && tr < 0) tr = i;
      if (i == 12) pend_seen = bus.Pending_Right && !bus.Emergency_Right;
    end
    total += 2;
    if (pend_seen !== 1'b1) begin bad++; $display("FAIL queue_pending got=%b exp=1", pend_seen); end
    if (tr - tl !== H + 1) begin bad++; $display("FAIL queue_spacing got=%0d exp=%0d", tr - tl, H + 1); end
  endtask

  task automatic toggle_left(inout int nl);
    for (int i = 0; i < 6; i++) begin
      step(i < 4, 1'b0);
      if (bus.Emergency_Left) nl++;
    end
  endtask

  task automatic test_drops();
    int nl;
    apply_reset();
    nl = 0;
    repeat (4) toggle_left(nl);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0);
      if (bus.Emergency_Left) nl++;
    end
    total += 2;
    if (bus.Dropped_Count !== 4'd2) begin
      bad++; $display("FAIL drops_two got=%0d exp=2", bus.Dropped_Count);
    end
    if (nl !== 2) begin bad++; $display("FAIL drops_pulses got=%0d exp=2", nl); end
    repeat (40) toggle_left(nl);
    total += 2;
    if (bus.Dropped_Count !== 4'd15) begin
      bad++; $display("FAIL drops_saturate got=%0d exp=15", bus.Dropped_Count);
    end
    if (bus.Dropped_Count !== 4'(m_drops)) begin
      bad++; $display("FAIL drops_model got=%0d exp=%0d", bus.Dropped_Count, m_drops);
    end
  endtask

  task automatic test_reset_mid_holdoff();
    logic pend;
    int np;
    apply_reset();
    pend = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step(i < 10, (i >= 6) && (i < 13));
      if (i == 13) pend = bus.Pending_Right;
    end
    total++;
    if (pend !== 1'b1) begin bad++; $display("FAIL midreset_pending got=%b exp=1", pend); end
    bus.Siren_Left_raw  = 1'b0;
    bus.Siren_Right_raw = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (dut_vec() !== 11'd0) begin
      bad++; $display("FAIL midreset_immediate got=%b exp=%b", dut_vec(), 11'd0);
    end
    apply_reset();
    np = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0);
      if (bus.Emergency_Right || bus.Emergency_Left) np++;
    end
    total++;
    if (np !== 0) begin bad++; $display("FAIL midreset_pulse got=%0d exp=0", np); end
  endtask

  task automatic test_random();
    int hold_l, hold_r;
    logic l, r;
    apply_reset();
    hold_l = 0; hold_r = 0; l = 1'b0; r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (hold_l == 0) begin l = 1'($urandom_range(0, 1)); hold_l = $urandom_range(1, 8); end
      if (hold_r == 0) begin r = 1'($urandom_range(0, 1)); hold_r = $urandom_range(1, 8); end
      hold_l--;
      hold_r--;
      if ($urandom_range(0, 399) == 0) apply_reset();
      step(l, r);
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    bus.Siren_Left_raw  = 1'b0;
    bus.Siren_Right_raw = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_single_left();
    test_glitch();
    test_both();
    test_holdoff_queue();
    test_drops();
    test_reset_mid_holdoff();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
